mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 20 ++
 rtl/mul_div_step.sv | 38 +++
 rtl/mul_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode and FSM
// state encodings plus the default operand width.
package mul_div_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the unsigned datapath: a shift-add multiply step (LSB first)
// or a restoring shift-subtract divide step on the {hi, lo} accumulator pair.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
        shifted = {hi_i, lo_i[WIDTH-1]};
        // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - b_i;
        if (is_div_i) begin
            if (shifted >= {1'b0, b_i}) begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shifted[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers, WIDTH+2 cycle latency.
// Divide opcodes are compiled in only when MUL_DIV_DIVIDE_EN is defined.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef MUL_DIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
    logic                    done_q, done_d;
    logic                    is_div_q, is_div_d;
    logic                    neg_q, neg_d;
    logic                    rem_neg_q, rem_neg_d;
    logic                    dz_q, dz_d;
    logic [WIDTH-1:0]        acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;

    op_e                     op;
    logic signed [WIDTH-1:0] rs_s, rt_s;
    logic                    is_signed, sign_a, sign_b, start_ok;
    logic [WIDTH-1:0]        step_hi, step_lo;
    logic [2*WIDTH-1:0]      product;
    logic [WIDTH-1:0]        res_hi, res_lo;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v, input logic en);
        return (en && (v < 0)) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    assign op        = op_e'(op_i);
    assign rs_s      = $signed(rs_data_i);
    assign rt_s      = $signed(rt_data_i);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = is_signed && (rs_s < 0);
    assign sign_b    = is_signed && (rt_s < 0);
    assign start_ok  = start_i && (DIV_EN || !(op == OP_DIVU || op == OP_DIV));

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Sign correction on the unsigned magnitudes; a zero divisor forces an all-ones quotient
    // while the remainder path already reproduces the raw dividend.
    always_comb begin
        product = neg_wide({acc_hi_q, acc_lo_q}, neg_q);
        if (is_div_q) begin
            res_lo = dz_q ? {WIDTH{1'b1}} : neg_word(acc_lo_q, neg_q);
            res_hi = neg_word(acc_hi_q, rem_neg_q);
        end else begin
            res_hi = product[2*WIDTH-1:WIDTH];
            res_lo = product[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        b_d       = b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    is_div_d  = DIV_EN && (op == OP_DIVU || op == OP_DIV);
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    dz_d      = (rt_data_i == '0);
                    acc_hi_d  = '0;
                    acc_lo_d  = abs_val(rs_s, is_signed);
                    b_d       = abs_val(rt_s, is_signed);
                end else begin
                    if (mthi_i) hi_d = rs_data_i;
                    if (mtlo_i) lo_d = rs_data_i;
                end
            end
            ST_CALC: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end
            end
            ST_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Operand/accumulator registers carry no reset; they are always reloaded at start.
    always_ff @(posedge clk_i) begin
        is_div_q  <= is_div_d;
        neg_q     <= neg_d;
        rem_neg_q <= rem_neg_d;
        dz_q      <= dz_d;
        acc_hi_q  <= acc_hi_d;
        acc_lo_q  <= acc_lo_d;
        b_q       <= b_d;
    end

`ifdef MUL_DIV_DIVIDE_EN
    logic dz_pulse_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dz_pulse_q <= 1'b0;
        end else begin
            dz_pulse_q <= (state_q == ST_FIX) && is_div_q && dz_q;
        end
    end

    assign div_zero_o = dz_pulse_q;
`else
    assign div_zero_o = 1'b0;
`endif

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit; divide scenarios follow MUL_DIV_DIVIDE_EN.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] rs_data_i = '0;
    logic [W-1:0] rt_data_i = '0;
    logic         mthi_i = 1'b0;
    logic         mtlo_i = 1'b0;
    logic [W-1:0] hi_o, lo_o;
    logic         busy_o, done_o, div_zero_o;

    int tests_run = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs_data_i  (rs_data_i),
        .rt_data_i  (rt_data_i),
        .mthi_i     (mthi_i),
        .mtlo_i     (mtlo_i),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o)
    );

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [63:0] p;
        longint signed sp;
        e.dz = 1'b0;
        case (op)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p = sp;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            default: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = '0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        sb.push_back(model(op, a, b));
        op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (done_o !== 1'b1 && cyc < 200) begin
            if (busy_o === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            e.hi = 'x; e.lo = 'x; e.dz = 1'bx;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1; rs_data_i = 32'hDEAD_BEEF;
        tick(); tick();
        tests_run++;
        if ({busy_o, done_o, div_zero_o, hi_o, lo_o} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
                     busy_o, done_o, div_zero_o, hi_o, lo_o);
        end
        rst_i = 1'b0; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        tick();
    endtask

    task automatic test_multu();
        int cyc, bc;
        exp_t e;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bc);
        tests_run++;
        if (cyc !== 33) begin
            fails++; $display("FAIL multu_latency: got %0d cycles, want 33", cyc);
        end
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o, div_zero_o} !== {e.hi, e.lo, e.dz}) begin
            fails++; $display("FAIL multu_sb: got %h_%h dz=%b, want %h_%h dz=%b", hi_o, lo_o, div_zero_o, e.hi, e.lo, e.dz);
        end
        tests_run++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001) begin
            fails++; $display("FAIL multu_max: got %h_%h, want fffffffe_00000001", hi_o, lo_o);
        end
        tick();
        tests_run++;
        if (done_o !== 1'b0) begin
            fails++; $display("FAIL done_pulse_width: done=%b one cycle later, want 0", done_o);
        end
    endtask

    task automatic test_mult();
        int cyc, bc;
        exp_t e;
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bc);
        tests_run++;
        if (bc !== 33) begin
            fails++; $display("FAIL mult_busy_len: busy %0d cycles, want 33", bc);
        end
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            fails++; $display("FAIL mult_sb: got %h_%h, want %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
        tests_run++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            fails++; $display("FAIL mult_neg3x7: got %h_%h, want ffffffff_ffffffeb", hi_o, lo_o);
        end
    endtask

    task automatic test_random_mul();
        int cyc, bc;
        exp_t e;
        logic [1:0] op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 6; i++) begin
            op = {1'b0, 1'($urandom_range(0, 1))};
            a = $urandom;
            b = $urandom;
            if (i == 0) begin op = 2'b01; a = 32'h8000_0000; b = 32'h8000_0000; end
            if (i == 1) begin op = 2'b01; a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
            if (i == 2) begin op = 2'b00; a = 32'h0; end
            issue(op, a, b);
            wait_done(cyc, bc);
            pop_exp(e);
            tests_run++;
            if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
                fails++;
                $display("FAIL rand_mul[%0d] op=%0d a=%h b=%h: got %h_%h, want %h_%h", i, op, a, b, hi_o, lo_o, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_moves();
        int cyc, bc;
        exp_t e;
        bit held;
        tick();
        rs_data_i = 32'h55; mtlo_i = 1'b1;
        tick();
        mtlo_i = 1'b0;
        tests_run++;
        if (lo_o !== 32'h55) begin
            fails++; $display("FAIL mtlo_idle: lo=%h, want 00000055", lo_o);
        end
        rs_data_i = 32'hA5A5; mthi_i = 1'b1; mtlo_i = 1'b1;
        tick();
        mthi_i = 1'b0; mtlo_i = 1'b0;
        tests_run++;
        if ({hi_o, lo_o} !== {32'hA5A5, 32'hA5A5}) begin
            fails++; $display("FAIL mthi_mtlo_both: got %h_%h, want 0000a5a5_0000a5a5", hi_o, lo_o);
        end
        issue(2'b00, 32'd3, 32'd5);
        held = 1'b1;
        rs_data_i = 32'h1234; mthi_i = 1'b1; mtlo_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (hi_o !== 32'hA5A5 || lo_o !== 32'hA5A5) held = 1'b0;
        end
        mthi_i = 1'b0; mtlo_i = 1'b0;
        tests_run++;
        if (held !== 1'b1) begin
            fails++; $display("FAIL move_while_busy: hi=%h lo=%h, want 0000a5a5 held", hi_o, lo_o);
        end
        wait_done(cyc, bc);
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            fails++; $display("FAIL mul_3x5: got %h_%h, want %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
        mthi_i = 1'b1;
        issue(2'b00, 32'd6, 32'd7);
        mthi_i = 1'b0;
        tests_run++;
        if (hi_o !== 32'h0 || busy_o !== 1'b1) begin
            fails++; $display("FAIL start_drops_move: hi=%h busy=%b, want 00000000 busy=1", hi_o, busy_o);
        end
        wait_done(cyc, bc);
        pop_exp(e);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        int cyc, bc;
        exp_t e;
        tick();
        rs_data_i = 32'h77; mtlo_i = 1'b1;
        tick();
        mtlo_i = 1'b0;
        issue(2'b00, 32'hFFFF, 32'hFFFF);
        void'(sb.pop_back());
        for (int i = 0; i < 9; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests_run++;
        if ({busy_o, done_o, hi_o, lo_o} !== '0) begin
            fails++; $display("FAIL reset_mid_calc: busy=%b done=%b hi=%h lo=%h, want all zero", busy_o, done_o, hi_o, lo_o);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o !== 1'b0 || busy_o !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            fails++; $display("FAIL reset_no_done: activity after reset, got 1 want 0");
        end
        issue(2'b00, 32'd6, 32'd7);
        wait_done(cyc, bc);
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o} !== {e.hi, e.lo} || lo_o !== 32'd42) begin
            fails++; $display("FAIL post_reset_6x7: got %h_%h, want 00000000_0000002a", hi_o, lo_o);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        exp_t e;
        issue(2'b01, 32'h1234_5678, 32'hFEDC_BA98);
        wait_done(cyc, bc);
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            fails++; $display("FAIL b2b_first: got %h_%h, want %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
        issue(2'b00, 32'hDEAD_BEEF, 32'h0000_1001);
        tests_run++;
        if (busy_o !== 1'b1) begin
            fails++; $display("FAIL b2b_accept: busy=%b, want 1", busy_o);
        end
        wait_done(cyc, bc);
        tests_run++;
        if (cyc !== 33) begin
            fails++; $display("FAIL b2b_spacing: got %0d cycles after accept, want 33", cyc);
        end
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            fails++; $display("FAIL b2b_second: got %h_%h, want %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
    endtask

`ifdef MUL_DIV_DIVIDE_EN
    task automatic test_divide();
        int cyc, bc;
        exp_t e;
        logic [1:0] op;
        logic [W-1:0] a, b;
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bc);
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o, div_zero_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0} || {hi_o, lo_o} !== {e.hi, e.lo}) begin
            fails++; $display("FAIL div_neg7_2: got %h_%h dz=%b, want ffffffff_fffffffd dz=0", hi_o, lo_o, div_zero_o);
        end
        issue(2'b10, 32'd100, 32'd0);
        wait_done(cyc, bc);
        pop_exp(e);
        tests_run++;
        if ({hi_o, lo_o, div_zero_o, cyc} !== {32'd100, 32'hFFFF_FFFF, 1'b1, 33} || e.dz !== 1'b1) begin
            fails++; $display("FAIL divu_zero: got %h_%h dz=%b cyc=%0d, want 00000064_ffffffff dz=1 cyc=33", hi_o, lo_o, div_zero_o, cyc);
        end
        tick();
        tests_run++;
        if (div_zero_o !== 1'b0) begin
            fails++; $display("FAIL div_zero_width: dz=%b, want 0", div_zero_o);
        end
        for (int i = 0; i < 8; i++) begin
            op = {1'b1, 1'($urandom_range(0, 1))};
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i == 0) begin op = 2'b11; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 1) begin op = 2'b11; a = 32'hFFFF_FF9C; b = 32'd0; end
            if (i == 2) begin op = 2'b11; a = 32'd7; b = 32'hFFFF_FFFE; end
            issue(op, a, b);
            wait_done(cyc, bc);
            pop_exp(e);
            tests_run++;
            if ({hi_o, lo_o, div_zero_o} !== {e.hi, e.lo, e.dz}) begin
                fails++;
                $display("FAIL rand_div[%0d] op=%0d a=%h b=%h: got %h_%h dz=%b, want %h_%h dz=%b",
                         i, op, a, b, hi_o, lo_o, div_zero_o, e.hi, e.lo, e.dz);
            end
        end
    endtask
`else
    task automatic test_divide_disabled();
        bit active;
        tick();
        rs_data_i = 32'h11; mthi_i = 1'b1;
        tick();
        rs_data_i = 32'h22; mthi_i = 1'b0; mtlo_i = 1'b1;
        tick();
        mtlo_i = 1'b0;
        op_i = 2'b10; rs_data_i = 32'd100; rt_data_i = 32'd3; start_i = 1'b1;
        active = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            start_i = 1'b0;
            if (busy_o !== 1'b0 || done_o !== 1'b0 || div_zero_o !== 1'b0) active = 1'b1;
        end
        tests_run++;
        if (active !== 1'b0) begin
            fails++; $display("FAIL div_disabled_idle: activity seen, got 1 want 0");
        end
        tests_run++;
        if ({hi_o, lo_o} !== {32'h11, 32'h22}) begin
            fails++; $display("FAIL div_disabled_hilo: got %h_%h, want 00000011_00000022", hi_o, lo_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_random_mul();
        test_moves();
        test_reset_mid();
        test_back_to_back();
`ifdef MUL_DIV_DIVIDE_EN
        test_divide();
`else
        test_divide_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
